sram: RTL and testbench
=======================

Name: sram

Overview:
- Dual-port synchronous RAM with one clock; BDD accelerator node/entry storage.
- Port A: write/read; port B: write/read; registered read data on both ports.
- Default geometry: 8 words x 34 bits. Each word packs {8-bit field2, 8-bit field1, 8-bit field0, 10-bit value}.

Parameters:
- ADDR_WIDTH, 3, address bits per port.
- DATA_WIDTH, 34, word width in bits.
- DEPTH, 8, number of words; must be <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr_a  in  ADDR_WIDTH  port A address.
- data_a  in  DATA_WIDTH  port A write data.
- we_a  in  1  port A write enable.
- q_a  out  DATA_WIDTH  port A registered read data.
- addr_b  in  ADDR_WIDTH  port B address.
- data_b  in  DATA_WIDTH  port B write data.
- we_b  in  1  port B write enable; tie low when unused.
- q_b  out  DATA_WIDTH  port B registered read data.

Behaviour:
- Reset (asynchronous assert, release at a clock edge):
  - q_a = 0, q_b = 0.
  - All DEPTH words cleared to 0.
  - Accesses are ignored while rst = 1.
- Write: on a rising edge with we_x = 1, mem[addr_x] <= data_x. Visible to any read on a later edge.
- Read: every edge, each port registers mem[addr_x] into q_x. Latency is 1 cycle; address applied before edge N gives data after edge N.
- Same-port read during write is write-first: when we_x = 1, q_x <= data_x on that edge.
- Cross-port collision, same address, both we = 1: port A wins. Port B's write is dropped. Both q_a and q_b return data_a.
- Cross-port read of an address the other port writes in the same cycle:
  - Without the optional feature, the reading port returns the old contents.
  - With the feature, see Optional Feature.
- Out-of-range address (addr >= DEPTH): write ignored; read returns 0.
- X or undriven we_x is treated as a no-write: the write gate is we_x === 1.
- Outputs hold their value between edges. There is no output enable.

Optional Feature:
- Macro: SRAM_BYPASS_EN.
- Defined: cross-port write forwarding. If port A writes address X while port B reads X on the same edge, q_b <= data_a; the symmetric case applies for B writing and A reading. Collision priority is unchanged (A wins).
- Undefined: cross-port same-cycle reads return the pre-write contents (read-old).

Decomposition:
- Package sram_pkg:
  - Default widths: ADDR_WIDTH, DATA_WIDTH, DEPTH.
  - Packed-word field widths and offsets: value [9:0], field0 [17:10], field1 [25:18], field2 [33:26].
  - A packed struct typedef for the word.
- Sub-module sram_port: per-port read/write register logic, instantiated twice. The storage array and collision arbitration stay in sram.

Test Plan:
- Fill and readback:
  - Port A writes addrs 0..7: 0 = {10,0,0,245} = 34'h0280000F5; 1 = {0,10,0,175}; 2 = {10,0,0,495}; 3 = {10,0,0,485}; 4 = {0,10,0,165}; 5 = {0,10,0,155}; 6 = {0,0,10,595}; 7 = {0,0,10,695}.
  - Then we_a = 0 and addr_b steps 0..7 -> q_b equals each word one cycle after its address.
- Reset: after the fill, assert rst mid-cycle -> q_a and q_b go to 0 immediately; after release, all reads return 0.
- Write-first: port A writes 34'h3_FFFF_FFFF to addr 2 -> q_a = 34'h3_FFFF_FFFF on that same edge.
- Collision: A writes 34'h1 and B writes 34'h2 to addr 5 on one edge -> next read of addr 5 gives 34'h1.
- Cross-port read of addr 3 while A writes 34'hAA to it:
  - SRAM_BYPASS_EN undefined -> q_b = old contents.
  - SRAM_BYPASS_EN defined -> q_b = 34'hAA.
- Idle port: we_b left X with addr_b = 4 -> mem[4] unchanged and q_b returns stored data.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: default geometry and packed-word layout for the BDD node RAM.
// Word = {field2[33:26], field1[25:18], field0[17:10], value[9:0]}.
package sram_pkg;

    localparam int SRAM_ADDR_W = 3;
    localparam int SRAM_DATA_W = 34;
    localparam int SRAM_DEPTH  = 8;

    localparam int VALUE_LSB  = 0;
    localparam int VALUE_W    = 10;
    localparam int FIELD0_LSB = 10;
    localparam int FIELD1_LSB = 18;
    localparam int FIELD2_LSB = 26;
    localparam int FIELD_W    = 8;

    typedef struct packed {
        logic [FIELD_W-1:0] field2;
        logic [FIELD_W-1:0] field1;
        logic [FIELD_W-1:0] field0;
        logic [VALUE_W-1:0] value;
    } sram_word_t;

    function automatic logic [SRAM_DATA_W-1:0] pack_word(
        input logic [FIELD_W-1:0] f2,
        input logic [FIELD_W-1:0] f1,
        input logic [FIELD_W-1:0] f0,
        input logic [VALUE_W-1:0] val
    );
        sram_word_t w;
        w.field2 = f2;
        w.field1 = f1;
        w.field0 = f0;
        w.value  = val;
        return w;
    endfunction

endpackage

// File: rtl/sram_port.sv
// sram_port: one access port -- range check, write gate, registered read data.
// Ports: clk, rst, addr_i, data_i, we_i, rdata_i (array word), fwd_i/fwd_data_i
// (override from the other port), hit_o (addr in range), wr_o (write valid), q_o.
module sram_port
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_W,
    parameter int DATA_WIDTH = SRAM_DATA_W,
    parameter int DEPTH      = SRAM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  fwd_i,
    input  logic [DATA_WIDTH-1:0] fwd_data_i,
    output logic                  hit_o,
    output logic                  wr_o,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] q_d;

    assign hit_o = 32'(addr_i) < 32'(DEPTH);
    // Only a definite 1 writes; X/Z on the enable is a no-write.
    assign wr_o  = hit_o && (we_i === 1'b1);

    // Forwarded data outranks the own write so a losing collision
    // write still reads back the winner's data.
    always_comb begin
        q_d = rdata_i;
        if (!hit_o)     q_d = '0;
        else if (fwd_i) q_d = fwd_data_i;
        else if (wr_o)  q_d = data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/sram.sv
// sram: dual-port single-clock RAM with registered reads, port A wins collisions.
// Ports: clk, rst, addr_a/data_a/we_a/q_a, addr_b/data_b/we_b/q_b.
// Macro SRAM_BYPASS_EN: forward same-cycle cross-port writes to the reading port.
module sram
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_W,
    parameter int DATA_WIDTH = SRAM_DATA_W,
    parameter int DEPTH      = SRAM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  we_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  hit_a, hit_b;
    logic                  wr_a, wr_b;
    logic                  same;
    logic                  fwd_a, fwd_b;
    logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

    assign same    = addr_a == addr_b;
    assign rdata_a = hit_a ? mem_q[addr_a] : '0;
    assign rdata_b = hit_b ? mem_q[addr_b] : '0;

`ifdef SRAM_BYPASS_EN
    assign fwd_b = wr_a && same;
    assign fwd_a = wr_b && same && !wr_a;
`else
    // Collision: B's dropped write still reads back A's data.
    assign fwd_b = wr_a && wr_b && same;
    assign fwd_a = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_a) mem_q[addr_a] <= data_a;
            if (wr_b && !(wr_a && same)) mem_q[addr_b] <= data_b;
        end
    end

    sram_port #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_port_a (
        .clk       (clk),
        .rst       (rst),
        .addr_i    (addr_a),
        .data_i    (data_a),
        .we_i      (we_a),
        .rdata_i   (rdata_a),
        .fwd_i     (fwd_a),
        .fwd_data_i(data_b),
        .hit_o     (hit_a),
        .wr_o      (wr_a),
        .q_o       (q_a)
    );

    sram_port #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_port_b (
        .clk       (clk),
        .rst       (rst),
        .addr_i    (addr_b),
        .data_i    (data_b),
        .we_i      (we_b),
        .rdata_i   (rdata_b),
        .fwd_i     (fwd_b),
        .fwd_data_i(data_a),
        .hit_o     (hit_b),
        .wr_o      (wr_b),
        .q_o       (q_b)
    );

endmodule

// File: tb/tb_sram.sv
// tb_sram: directed checks of fill/readback, reset, write-first,
// collision, cross-port read and an X write enable.
module tb_sram;
    import sram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  addr_a, addr_b;
    logic [33:0] data_a, data_b;
    logic        we_a, we_b;
    logic [33:0] q_a, q_b;

    int checks = 0;
    int errors = 0;

    logic [33:0] words [8];
    logic [33:0] exp_x;

    sram dut (
        .clk   (clk),
        .rst   (rst),
        .addr_a(addr_a),
        .data_a(data_a),
        .we_a  (we_a),
        .q_a   (q_a),
        .addr_b(addr_b),
        .data_b(data_b),
        .we_b  (we_b),
        .q_b   (q_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [33:0] got,
                         input logic [33:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        words[0] = 34'h0280000F5;
        words[1] = 34'h0002800AF;
        words[2] = 34'h0280001EF;
        words[3] = 34'h0280001E5;
        words[4] = 34'h0002800A5;
        words[5] = 34'h00028009B;
        words[6] = 34'h000002A53;
        words[7] = 34'h000002AB7;

        rst = 1'b1;
        addr_a = '0; addr_b = '0;
        data_a = '0; data_b = '0;
        we_a = 1'b0; we_b = 1'b0;
        tick();
        tick();
        check("rst_qa", q_a, 34'h0);
        check("rst_qb", q_b, 34'h0);
        rst = 1'b0;

        check("pack0", pack_word(8'd10, 8'd0, 8'd0, 10'd245), words[0]);
        check("pack7", pack_word(8'd0, 8'd0, 8'd10, 10'd695), words[7]);

        for (int i = 0; i < 8; i++) begin
            addr_a = 3'(i); data_a = words[i]; we_a = 1'b1;
            tick();
            check($sformatf("fill_wf%0d", i), q_a, words[i]);
        end
        we_a = 1'b0;

        for (int i = 0; i < 8; i++) begin
            addr_b = 3'(i);
            tick();
            check($sformatf("rdb%0d", i), q_b, words[i]);
        end

        #3 rst = 1'b1;
        #1;
        check("arst_qa", q_a, 34'h0);
        check("arst_qb", q_b, 34'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addr_a = 3'(i); addr_b = 3'(7 - i);
            tick();
            check($sformatf("clr_a%0d", i), q_a, 34'h0);
            check($sformatf("clr_b%0d", i), q_b, 34'h0);
        end

        addr_a = 3'd2; data_a = 34'h3_FFFF_FFFF; we_a = 1'b1;
        tick();
        check("wfirst", q_a, 34'h3_FFFF_FFFF);
        addr_a = 3'd3; data_a = 34'h55;
        tick();
        we_a = 1'b0; addr_b = 3'd2;
        tick();
        check("wfirst_mem", q_b, 34'h3_FFFF_FFFF);

        addr_a = 3'd5; addr_b = 3'd5;
        data_a = 34'h1; data_b = 34'h2;
        we_a = 1'b1; we_b = 1'b1;
        tick();
        check("coll_qa", q_a, 34'h1);
        check("coll_qb", q_b, 34'h1);
        we_a = 1'b0; we_b = 1'b0;
        tick();
        check("coll_rd_a", q_a, 34'h1);
        check("coll_rd_b", q_b, 34'h1);

        addr_a = 3'd3; data_a = 34'hAA; we_a = 1'b1;
        addr_b = 3'd3;
`ifdef SRAM_BYPASS_EN
        exp_x = 34'hAA;
`else
        exp_x = 34'h55;
`endif
        tick();
        check("xport_qb", q_b, exp_x);
        we_a = 1'b0;
        tick();
        check("xport_after", q_b, 34'hAA);

        addr_a = 3'd4; data_a = words[4]; we_a = 1'b1;
        tick();
        we_a = 1'b0; addr_a = 3'd0;
        addr_b = 3'd4; data_b = 34'h123; we_b = 1'bx;
        tick();
        check("idle_qb", q_b, words[4]);
        tick();
        check("idle_qb2", q_b, words[4]);
        we_b = 1'b0; addr_a = 3'd4;
        tick();
        check("idle_mem", q_a, words[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
